// File: rtl/even_issue_queue_pkg.sv
// rtl/even_issue_queue_pkg.sv - shared types, constants and source-mask helper for the even issue queue
package even_issue_queue_pkg;

  localparam logic [0:7] NO_SRC_ADDR = 8'h80;

  localparam logic [2:0] FMT_RR   = 3'd0;
  localparam logic [2:0] FMT_RRR  = 3'd1;
  localparam logic [2:0] FMT_RI7  = 3'd3;
  localparam logic [2:0] FMT_RI10 = 3'd4;

  typedef struct packed {
    logic [0:10] op;
    logic [2:0]  format;
    logic [0:6]  rt_addr;
    logic [0:6]  ra_addr;
    logic [0:6]  rb_addr;
    logic [0:6]  rc_addr;
    logic [0:17] imm;
    logic        reg_write;
  } even_instr_t;

  // Returns {ra_used, rb_used, rc_used}; a nop (RR format, op[0:9] zero) uses nothing.
  function automatic logic [2:0] src_mask(input logic [2:0] fmt, input logic [0:9] op_hi);
    logic [2:0] m;
    m = 3'b000;
    if (!(fmt == FMT_RR && op_hi == '0)) begin
      m = {1'b1, (fmt == FMT_RR) || (fmt == FMT_RRR), fmt == FMT_RRR};
    end
    return m;
  endfunction

endpackage

// File: rtl/even_issue_queue_if.sv
// rtl/even_issue_queue_if.sv - decoder-to-queue push channel
interface even_issue_queue_if;
  import even_issue_queue_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [0:10] in_op;
  logic [2:0]  in_format;
  logic [0:6]  in_rt_addr;
  logic [0:6]  in_ra_addr;
  logic [0:6]  in_rb_addr;
  logic [0:6]  in_rc_addr;
  logic [0:17] in_imm;
  logic        in_reg_write;

  modport master (
    output in_valid, in_op, in_format, in_rt_addr, in_ra_addr, in_rb_addr,
           in_rc_addr, in_imm, in_reg_write,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_format, in_rt_addr, in_ra_addr, in_rb_addr,
           in_rc_addr, in_imm, in_reg_write,
    output in_ready
  );
endinterface

// File: rtl/even_issue_queue_fifo.sv
// rtl/even_issue_queue_fifo.sv - circular buffer of decoded even-pipe instructions
module even_issue_queue_fifo
  import even_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  even_instr_t wr_data,
  output even_instr_t rd_data,
  output logic [PTR_W:0] count
);

  even_instr_t      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Entry storage; caller only asserts push when there is room.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two; flush empties the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[head];

endmodule

// File: rtl/even_issue_queue.sv
// rtl/even_issue_queue.sv - even-pipe issue queue: buffering, hazard addresses, operand capture, nop insertion
module even_issue_queue
  import even_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  even_issue_queue_if.slave bus,
  output logic [0:7]      ra_even_addr,
  output logic [0:7]      rb_even_addr,
  output logic [0:7]      rc_even_addr,
  input  logic            stall_even_raw,
  input  logic            branch_taken,
  input  logic [0:127]    rf_ra_data,
  input  logic [0:127]    rf_rb_data,
  input  logic [0:127]    rf_rc_data,
  output logic [0:10]     op,
  output logic [2:0]      format,
  output logic [0:6]      rt_addr,
  output logic [0:17]     imm,
  output logic            reg_write,
  output logic [0:127]    ra,
  output logic [0:127]    rb,
  output logic [0:127]    rc,
  output logic [PTR_W:0]  count
);

  even_instr_t wr_entry;
  even_instr_t head;
  logic        not_empty;
  logic        push;
  logic        issue;
  logic [2:0]  used;

  assign wr_entry = '{op: bus.in_op, format: bus.in_format, rt_addr: bus.in_rt_addr,
                      ra_addr: bus.in_ra_addr, rb_addr: bus.in_rb_addr,
                      rc_addr: bus.in_rc_addr, imm: bus.in_imm,
                      reg_write: bus.in_reg_write};

  assign not_empty    = (count != '0);
  assign bus.in_ready = (count != (PTR_W+1)'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready && !branch_taken;
  assign issue        = not_empty && !stall_even_raw && !branch_taken;

  even_issue_queue_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (issue),
    .flush   (branch_taken),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (count)
  );

  // Sources the head does not read are reported as 8'h80 so they never match a destination.
  assign used         = not_empty ? src_mask(head.format, head.op[0:9]) : 3'b000;
  assign ra_even_addr = used[2] ? {1'b0, head.ra_addr} : NO_SRC_ADDR;
  assign rb_even_addr = used[1] ? {1'b0, head.rb_addr} : NO_SRC_ADDR;
  assign rc_even_addr = used[0] ? {1'b0, head.rc_addr} : NO_SRC_ADDR;

  // Issue register: head instruction and its operands when issuing, otherwise an all-zero nop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op        <= '0;
      format    <= '0;
      rt_addr   <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
    end else if (issue) begin
      op        <= head.op;
      format    <= head.format;
      rt_addr   <= head.rt_addr;
      imm       <= head.imm;
      reg_write <= head.reg_write;
      ra        <= used[2] ? rf_ra_data : '0;
      rb        <= used[1] ? rf_rb_data : '0;
      rc        <= used[0] ? rf_rc_data : '0;
    end else begin
      op        <= '0;
      format    <= '0;
      rt_addr   <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
    end
  end

endmodule

// File: tb/tb_even_issue_queue.sv
// tb/tb_even_issue_queue.sv - directed self-checking bench for even_issue_queue
module tb_even_issue_queue;

  logic          clk = 1'b0;
  logic          reset;
  logic [0:7]    ra_even_addr, rb_even_addr, rc_even_addr;
  logic          stall_even_raw;
  logic          branch_taken;
  logic [0:127]  rf_ra_data, rf_rb_data, rf_rc_data;
  logic [0:10]   op;
  logic [2:0]    format;
  logic [0:6]    rt_addr;
  logic [0:17]   imm;
  logic          reg_write;
  logic [0:127]  ra, rb, rc;
  logic [2:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  even_issue_queue_if bus();

  even_issue_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .ra_even_addr   (ra_even_addr),
    .rb_even_addr   (rb_even_addr),
    .rc_even_addr   (rc_even_addr),
    .stall_even_raw (stall_even_raw),
    .branch_taken   (branch_taken),
    .rf_ra_data     (rf_ra_data),
    .rf_rb_data     (rf_rb_data),
    .rf_rc_data     (rf_rc_data),
    .op             (op),
    .format         (format),
    .rt_addr        (rt_addr),
    .imm            (imm),
    .reg_write      (reg_write),
    .ra             (ra),
    .rb             (rb),
    .rc             (rc),
    .count          (count)
  );

  always #5 clk = ~clk;

  // Register-file model: data tagged with the address it was read from.
  function automatic logic [0:127] rfv(input logic [0:7] a);
    return {{15{8'hA5}}, a};
  endfunction

  assign rf_ra_data = rfv(ra_even_addr);
  assign rf_rb_data = rfv(rb_even_addr);
  assign rf_rc_data = rfv(rc_even_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [0:10] o, input logic [2:0] f, input logic [0:6] rt,
                       input logic [0:6] a, input logic [0:6] b, input logic [0:6] c,
                       input logic [0:17] im, input logic rw);
    bus.in_valid     = 1'b1;
    bus.in_op        = o;
    bus.in_format    = f;
    bus.in_rt_addr   = rt;
    bus.in_ra_addr   = a;
    bus.in_rb_addr   = b;
    bus.in_rc_addr   = c;
    bus.in_imm       = im;
    bus.in_reg_write = rw;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    stall_even_raw = 1'b0;
    branch_taken = 1'b0;
    bus.in_valid = 1'b0;
    drive(11'd0, 3'd0, 7'd0, 7'd0, 7'd0, 7'd0, 18'd0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (reg_write !== 1'b0 || op !== 11'd0) begin n_fail++; $display("FAIL reset_nop: got op=%h rw=%b expected 0/0", op, reg_write); end
    n_checks++; if (ra_even_addr !== 8'h80) begin n_fail++; $display("FAIL reset_ra_addr: got %h expected 80", ra_even_addr); end
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_issue();
    drive(11'b01111000100, 3'd0, 7'd5, 7'd1, 7'd2, 7'd0, 18'd0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL mpy_count: got %0d expected 1", count); end
    n_checks++; if ({ra_even_addr, rb_even_addr, rc_even_addr} !== 24'h010280) begin
      n_fail++; $display("FAIL mpy_haz_addr: got %h %h %h expected 01 02 80", ra_even_addr, rb_even_addr, rc_even_addr); end
    n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL mpy_latency: got rw=%b expected 0 one edge after push", reg_write); end
    step();
    n_checks++; if (op !== 11'b01111000100 || rt_addr !== 7'd5 || reg_write !== 1'b1) begin
      n_fail++; $display("FAIL mpy_issue: got op=%b rt=%0d rw=%b expected 01111000100/5/1", op, rt_addr, reg_write); end
    n_checks++; if (ra !== rfv(8'h01) || rb !== rfv(8'h02) || rc !== 128'd0) begin
      n_fail++; $display("FAIL mpy_operands: got ra=%h rb=%h rc=%h", ra, rb, rc); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mpy_count_after: got %0d expected 0", count); end
    step();
    n_checks++; if (reg_write !== 1'b0 || op !== 11'd0) begin n_fail++; $display("FAIL mpy_bubble: got op=%h rw=%b expected 0/0", op, reg_write); end
  endtask

  task automatic test_stall();
    stall_even_raw = 1'b1;
    drive(11'b11100000000, 3'd1, 7'd7, 7'd3, 7'd4, 7'd6, 18'd0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rc_even_addr !== 8'h06 || count !== 3'd1 || reg_write !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold_%0d: got rc_addr=%h count=%0d rw=%b expected 06/1/0", i, rc_even_addr, count, reg_write); end
      step();
    end
    n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL stall_no_issue: got rw=%b expected 0", reg_write); end
    stall_even_raw = 1'b0;
    step();
    n_checks++; if (reg_write !== 1'b1 || rt_addr !== 7'd7 || format !== 3'd1 || count !== 3'd0) begin
      n_fail++; $display("FAIL fma_issue: got rw=%b rt=%0d fmt=%0d count=%0d expected 1/7/1/0", reg_write, rt_addr, format, count); end
    n_checks++; if (ra !== rfv(8'h03) || rb !== rfv(8'h04) || rc !== rfv(8'h06)) begin
      n_fail++; $display("FAIL fma_operands: got ra=%h rb=%h rc=%h", ra, rb, rc); end
  endtask

  task automatic test_full();
    stall_even_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(11'b00001110100, 3'd3, 7'(10 + i), 7'd1, 7'd0, 7'd0, 18'd0, 1'b1);
      step();
    end
    n_checks++; if (count !== 3'd4 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_state: got count=%0d ready=%b expected 4/0", count, bus.in_ready); end
    drive(11'b00001110100, 3'd3, 7'd14, 7'd1, 7'd0, 7'd0, 18'd0, 1'b1);
    step();
    n_checks++; if (count !== 3'd4 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_hold: got count=%0d ready=%b expected 4/0", count, bus.in_ready); end
    stall_even_raw = 1'b0;
    step();
    n_checks++; if (rt_addr !== 7'd10 || count !== 3'd3 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_first_issue: got rt=%0d count=%0d ready=%b expected 10/3/1", rt_addr, count, bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (rt_addr !== 7'd11 || count !== 3'd3) begin
      n_fail++; $display("FAIL full_push_and_issue: got rt=%0d count=%0d expected 11/3", rt_addr, count); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (rt_addr !== 7'(12 + i) || reg_write !== 1'b1 || count !== 3'(2 - i)) begin
        n_fail++; $display("FAIL full_order_%0d: got rt=%0d rw=%b count=%0d expected %0d/1/%0d", i, rt_addr, reg_write, count, 12 + i, 2 - i); end
    end
  endtask

  task automatic test_immediate();
    drive(11'b01110100000, 3'd4, 7'd8, 7'd9, 7'd12, 7'd13, 18'h01234, 1'b1);
    step();
    bus.in_valid = 1'b0;
    n_checks++; if ({ra_even_addr, rb_even_addr, rc_even_addr} !== 24'h098080) begin
      n_fail++; $display("FAIL mpyi_haz_addr: got %h %h %h expected 09 80 80", ra_even_addr, rb_even_addr, rc_even_addr); end
    step();
    n_checks++; if (ra !== rfv(8'h09) || rb !== 128'd0 || rc !== 128'd0) begin
      n_fail++; $display("FAIL mpyi_operands: got ra=%h rb=%h rc=%h", ra, rb, rc); end
    n_checks++; if (imm !== 18'h01234 || format !== 3'd4 || rt_addr !== 7'd8) begin
      n_fail++; $display("FAIL mpyi_fields: got imm=%h fmt=%0d rt=%0d expected 01234/4/8", imm, format, rt_addr); end
  endtask

  task automatic test_flush();
    stall_even_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(11'b00001110100, 3'd3, 7'(20 + i), 7'd2, 7'd0, 7'd0, 18'd0, 1'b1);
      step();
    end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    drive(11'b00001110100, 3'd3, 7'h63, 7'd2, 7'd0, 7'd0, 18'd0, 1'b1);
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    bus.in_valid = 1'b0;
    stall_even_raw = 1'b0;
    n_checks++; if (count !== 3'd0 || reg_write !== 1'b0 || op !== 11'd0 || ra_even_addr !== 8'h80) begin
      n_fail++; $display("FAIL flush_state: got count=%0d rw=%b op=%h ra_addr=%h expected 0/0/0/80", count, reg_write, op, ra_even_addr); end
    step();
    n_checks++; if (reg_write !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL flush_discard: got rw=%b rt=%0d count=%0d expected 0 and empty", reg_write, rt_addr, count); end
    drive(11'b00001110100, 3'd3, 7'h21, 7'd2, 7'd0, 7'd0, 18'd0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    n_checks++; if (rt_addr !== 7'h21 || reg_write !== 1'b1) begin
      n_fail++; $display("FAIL flush_resume: got rt=%h rw=%b expected 21/1", rt_addr, reg_write); end
  endtask

  task automatic test_async_reset();
    stall_even_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(11'b00001110100, 3'd3, 7'(30 + i), 7'd2, 7'd0, 7'd0, 18'd0, 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    stall_even_raw = 1'b0;
    step();
    stall_even_raw = 1'b1;
    n_checks++; if (count !== 3'd2 || reg_write !== 1'b1 || rt_addr !== 7'd30) begin
      n_fail++; $display("FAIL areset_pre: got count=%0d rw=%b rt=%0d expected 2/1/30", count, reg_write, rt_addr); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL areset_count: got count=%0d ready=%b expected 0/1", count, bus.in_ready); end
    n_checks++; if (reg_write !== 1'b0 || rt_addr !== 7'd0 || op !== 11'd0 || ra !== 128'd0) begin
      n_fail++; $display("FAIL areset_outputs: got rw=%b rt=%0d op=%h expected all 0", reg_write, rt_addr, op); end
    step();
    reset = 1'b1;
    stall_even_raw = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_stall();
    test_full();
    test_immediate();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/even_issue_queue.md
Name: even_issue_queue

Overview:
- Issue side of the even-pipe execute interface: buffers decoded even-pipe instructions from the decoder in a small circular FIFO.
- Presents the head instruction's source register addresses to the even-pipe RAW hazard check and reads its operands from the register file.
- Drives the even pipe's RF/FWD-stage inputs (op, format, rt_addr, ra, rb, rc, imm, reg_write) from registers, issuing at most one instruction per cycle.
- Holds while stall_even_raw is high; flushes on branch_taken.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >=2)
PTR_W, $clog2(DEPTH), read/write pointer width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decoder presents an even-pipe instruction
in_ready  out  1  queue can accept an entry this cycle
in_op  in  11 [0:10]  decoded opcode
in_format  in  3 [2:0]  instruction format
in_rt_addr  in  7 [0:6]  destination register
in_ra_addr, in_rb_addr, in_rc_addr  in  7 [0:6] each  source registers
in_imm  in  18 [0:17]  immediate
in_reg_write  in  1  instruction writes RegTable
ra_even_addr, rb_even_addr, rc_even_addr  out  8 [0:7] each  head source addresses to hazard check; combinational
stall_even_raw  in  1  RAW hazard on head sources, from even pipe
branch_taken  in  1  flush request
rf_ra_data, rf_rb_data, rf_rc_data  in  128 [0:127] each  register-file read data for head sources (combinational read of the *_even_addr low 7 bits)
op, format, rt_addr, imm, reg_write  out  11/3/7/18/1  registered issue fields to the even pipe
ra, rb, rc  out  128 [0:127] each  registered operands to the even pipe
count  out  PTR_W+1  current occupancy

Behaviour:
- Reset (reset=0, asynchronous): head=tail=count=0; all issue outputs 0, which encodes a nop (format 0, op 0, reg_write 0).
- Storage: DEPTH entries of {op, format, rt_addr, ra/rb/rc addr, imm, reg_write}.
- Pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH). It does not depend on a same-cycle pop.
- Push: in_valid && in_ready && !branch_taken. Entry is written at tail; tail increments.
- Hazard addresses: driven when count != 0. Unused sources are driven 8'h80, which never matches a 7-bit destination.
  - ra_even_addr = {0, head ra_addr}, except nop.
  - rb_even_addr = {0, head rb_addr} for format 0 and format 1 only.
  - rc_even_addr = {0, head rc_addr} for format 1 only.
  - Empty queue or nop head (format 0, op[0:9]=0): all three are 8'h80.
- Issue condition: count != 0 && !stall_even_raw && !branch_taken.
  - On issue, the registered outputs load the head entry fields and rf_*_data; head increments.
  - For a source driven 8'h80, the corresponding ra/rb/rc output is loaded with 0.
- Otherwise the registered outputs load a nop: all fields 0, including reg_write=0. Stall cycles therefore insert bubbles; the same instruction is never issued twice.
- Simultaneous push and issue: count is unchanged.
- Push when empty: entry is at head in the next cycle. Earliest issue-register update is the edge after that, so push-to-output latency is 2 cycles.
- Flush (branch_taken=1): on the next edge, head=tail=count=0 and issue outputs become a nop. A concurrent push is discarded. Flush has priority over stall.
- Full queue with in_valid held: in_ready=0 and no entry is overwritten. in_ready rises the cycle after an issue.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Decomposition:
- Shared package (spu_pkg):
  - typedef even_instr_t: {op, format, rt_addr, ra_addr, rb_addr, rc_addr, imm, reg_write}.
  - Constants: NO_SRC_ADDR = 8'h80; format codes FMT_RR=0, FMT_RRR=1, FMT_RI7=3, FMT_RI10=4.
  - Function src_mask(format, op) returning which of ra/rb/rc are used.
- Sub-module issue_fifo: generic DEPTH x even_instr_t circular buffer with push/pop/flush/count.
- even_issue_queue adds address masking, operand capture and the nop insertion.

Test Plan:
- Reset, then push mpy (format 0, op 01111000100, rt=5, ra=1, rb=2); rf_ra_data=rf_rb_data=128'h...0003 -> two edges later op=01111000100, rt_addr=5, ra/rb latched, reg_write=1; next cycle reg_write=0 (nop).
- Push fma (format 1) with ra=3, rb=4, rc=6 while stall_even_raw=1 for 3 cycles -> rc_even_addr=8'h06 throughout, outputs nop for 3 cycles, issue on the first cycle after stall drops; count goes 1->0.
- Push 5 instructions back-to-back with stall held, DEPTH=4 -> in_ready=0 after 4th push, count=4, 5th held; release stall -> issue in order, 5th accepted the cycle after first issue.
- Push mpyi (format 4, ra=9) -> rb_even_addr=rc_even_addr=8'h80, rb/rc outputs 0.
- With count=3, assert branch_taken with in_valid=1 -> next cycle count=0, outputs nop, pushed entry absent; subsequent push issues normally.
- Drop reset between clock edges while count=2 -> outputs and count 0 immediately, in_ready=1.
